uart_fifo_port: RTL and testbench
=================================

Name: uart_fifo_port

Overview:
Parametrised successor to the single-byte serial port. It is a full-duplex UART with configurable bit divisor, data width and parity mode. Separate TX and RX FIFOs decouple it from the CPU bus. It keeps the int_req/int_ack interrupt handshake toward the interrupt controller, and adds sticky error reporting (parity, framing, overrun).

Parameters:
DIVISOR, 434, clock cycles per serial bit (>=8); 434 gives 115200 baud at 50 MHz.
DATA_BITS, 8, payload bits per frame, 5..8, sent LSB first.
PARITY_EN, 0, 1 = one parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1).
FIFO_DEPTH, 16, entries per FIFO; power of two, >=2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
data_in  in  DATA_BITS  byte to transmit.
write_enable  in  1  push data_in into TX FIFO.
write_not_busy  out  1  TX FIFO not full.
read_enable  in  1  pop RX FIFO head.
data_out  out  DATA_BITS  RX FIFO head (show-ahead).
rx_valid  out  1  RX FIFO not empty.
int_req  out  1  interrupt request.
int_ack  in  1  interrupt acknowledge, one-cycle pulse.
err_clr  in  1  clears all sticky error flags.
parity_err  out  1  sticky: a frame with bad parity was discarded.
frame_err  out  1  sticky: a frame with low stop bit was discarded.
overrun  out  1  sticky: a good frame was dropped because the RX FIFO was full.
TxD  out  1  serial output, idle high.
RxD  in  1  serial input, asynchronous.

Behaviour:
- Reset (rst=0, asynchronous):
  - TxD=1, write_not_busy=1, rx_valid=0, data_out=0, int_req=0, all error flags 0.
  - Both FIFOs empty; both FSMs return to IDLE. Reset mid-frame aborts the frame immediately.
- TX FIFO:
  - A push occurs when write_enable=1 and write_not_busy=1.
  - A write while full is ignored and its data is lost.
  - write_not_busy reflects the new occupancy on the cycle after the push.
- TX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and enter START.
  - From an idle FIFO, the start bit appears on TxD at the second rising edge after the write.
  - Every bit lasts exactly DIVISOR cycles, timed by a bit counter that reloads at each bit boundary.
  - DATA sends DATA_BITS bits, LSB first.
  - PARITY is skipped when PARITY_EN=0. The parity bit is the XOR of the data bits, inverted when PARITY_ODD=1.
  - STOP holds TxD=1 for one bit time. If the FIFO is non-empty at the end of STOP, go straight to START with no extra idle cycle.
- RX front end: RxD passes through a 2-flop synchroniser. All RX decisions use the synchronised signal.
- RX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
  - IDLE: a high-to-low transition enters START.
  - START: wait DIVISOR/2 cycles, then sample. If the line is high, it was a glitch: return to IDLE and record nothing.
  - From START, later samples are taken every DIVISOR cycles, so each sample lands mid-bit.
  - DATA shifts in LSB first. PARITY samples and checks the parity bit.
  - STOP sample = 0: set frame_err and discard the byte.
  - STOP sample = 1 with bad parity: set parity_err and discard the byte.
  - Otherwise push the byte. If the FIFO is full, set overrun and drop the new byte; existing entries are unchanged.
  - The FSM returns to IDLE right after the stop sample, half a bit early, so it can resynchronise to the next start bit.
- RX FIFO:
  - data_out and rx_valid are registered and update the cycle after a push or pop.
  - read_enable with rx_valid=1 pops. read_enable while empty is ignored.
  - A simultaneous push and pop keeps the occupancy unchanged and never counts as overflow, even when full.
- Interrupts and errors:
  - int_req sets on the cycle after any push into the RX FIFO or any error-flag set event.
  - int_req clears on the cycle after int_ack=1.
  - If a set event and int_ack coincide, set wins.
  - err_clr clears all three error flags; a new error in the same cycle wins.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. The extra MSB distinguishes full from empty.

Test Plan:
1. Reset, then write 0xA5 (DIVISOR=16, DATA_BITS=8, parity even). TxD must show start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit exactly 16 cycles. write_not_busy stays 1.
2. Loop TxD to RxD and send 0x3C, 0xFF. rx_valid rises and data_out=0x3C. int_req asserts; int_ack clears it one cycle later. After read_enable, data_out=0xFF.
3. Write 17 bytes back-to-back with FIFO_DEPTH=16 while the transmitter is busy. write_not_busy drops at 16 entries and the 17th write is ignored. 16 frames then go out contiguously with no idle gap between stop and start.
4. Drive RxD frames of 0x55 with wrong parity, then 0x55 with stop=0. The first sets parity_err, the second sets frame_err. rx_valid stays 0, int_req asserts, and err_clr clears both flags.
5. Fill the RX FIFO with 16 frames without reading, then send a 17th. overrun=1 and the head is still the first byte. Next, with 16 entries, a 17th frame's push coincides with read_enable: no overrun, and the count stays 16.
6. Apply a 4-cycle low glitch on RxD: no frame is received. Apply rst=0 mid-TX frame: TxD=1 immediately and the FIFOs are empty.

Source files
------------

// File: rtl/uart_fifo_port.sv
// Full-duplex UART with TX/RX FIFOs, optional parity, sticky error flags
// and a level int_req / pulse int_ack interrupt handshake.
module uart_fifo_port #(
  parameter int DIVISOR    = 434,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 write_enable,
  output logic                 write_not_busy,
  input  logic                 read_enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 int_req,
  input  logic                 int_ack,
  input  logic                 err_clr,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 TxD,
  input  logic                 RxD
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];

  state_e               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic                 tx_par_q, tx_par_d, txd_q, txd_d, rx_pbad_q, rx_pbad_d;
  logic [PW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 rx_valid_q, rx_valid_d, int_req_q, int_req_d;
  logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;

  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_load, tx_last;
  logic                 rx_full, rx_push, rx_pop, rx_push_req, rx_last;
  logic                 par_evt, frm_evt, ovr_evt;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
  assign tx_last  = (tx_cnt_q == '0);
  assign rx_last  = (rx_cnt_q == '0);

  // Transmitter: a bit counter reloads at every bit boundary; STOP chains straight into START.
  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path can infer a latch.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_last ? BIT_LOAD : tx_cnt_q - 1'b1;
    case (tx_state_q)
      S_IDLE:  tx_load = !tx_empty;
      S_START: if (tx_last) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
        txd_d      = tx_shift_q[0];
      end
      S_DATA: if (tx_last) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = PARITY_EN ? S_PARITY : S_STOP;
          txd_d      = PARITY_EN ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          txd_d    = tx_shift_q[1];
        end
      end
      S_PARITY: if (tx_last) begin
        tx_state_d = S_STOP;
        txd_d      = 1'b1;
      end
      S_STOP: if (tx_last) begin
        tx_state_d = S_IDLE;
        tx_load    = !tx_empty;
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_d = S_START;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ PARITY_ODD;
      txd_d      = 1'b0;
      tx_cnt_d   = BIT_LOAD;
    end
  end

  // Receiver: half-bit wait after the falling edge puts every later sample mid-bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_pbad_d   = rx_pbad_q;
    rx_push_req = 1'b0;
    par_evt     = 1'b0;
    frm_evt     = 1'b0;
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_last ? BIT_LOAD : rx_cnt_q - 1'b1;
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = HALF_LOAD;
      end
      S_START: if (rx_last) begin
        if (rx_sync_q) rx_state_d = S_IDLE;
        else begin
          rx_state_d = S_DATA;
          rx_bit_d   = '0;
        end
      end
      S_DATA: if (rx_last) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = PARITY_EN ? S_PARITY : S_STOP;
        else                      rx_bit_d   = rx_bit_q + 1'b1;
      end
      S_PARITY: if (rx_last) begin
        rx_pbad_d  = rx_sync_q ^ (^rx_shift_q) ^ PARITY_ODD;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_last) begin
        rx_state_d = S_IDLE;
        if (!rx_sync_q)     frm_evt     = 1'b1;
        else if (rx_pbad_q) par_evt     = 1'b1;
        else                rx_push_req = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, registered show-ahead head, sticky flags and interrupt.
  always_comb begin
    tx_push    = write_enable && !tx_full;
    tx_wr_d    = tx_wr_q + PW'(tx_push);
    tx_rd_d    = tx_rd_q + PW'(tx_pop);
    rx_pop     = read_enable && rx_valid_q;
    rx_push    = rx_push_req && (!rx_full || rx_pop);
    ovr_evt    = rx_push_req && rx_full && !rx_pop;
    rx_wr_d    = rx_wr_q + PW'(rx_push);
    rx_rd_d    = rx_rd_q + PW'(rx_pop);
    rx_valid_d = (rx_wr_d != rx_rd_d);
    data_out_d = data_out_q;
    // The new head may be the byte being written this very cycle.
    if ((rx_push || rx_pop) && rx_valid_d)
      data_out_d = (rx_push && rx_rd_d == rx_wr_q) ? rx_shift_q : rx_mem[rx_rd_d[AW-1:0]];
    parity_err_d = par_evt || (parity_err_q && !err_clr);
    frame_err_d  = frm_evt || (frame_err_q && !err_clr);
    overrun_d    = ovr_evt || (overrun_q && !err_clr);
    int_req_d    = rx_push || par_evt || frm_evt || ovr_evt || (int_req_q && !int_ack);
  end

  // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= data_in;
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;        rx_state_q   <= S_IDLE;
      tx_cnt_q   <= '0;            rx_cnt_q     <= '0;
      tx_shift_q <= '0;            rx_shift_q   <= '0;
      tx_bit_q   <= '0;            rx_bit_q     <= '0;
      tx_par_q   <= 1'b0;          rx_pbad_q    <= 1'b0;
      txd_q      <= 1'b1;          data_out_q   <= '0;
      tx_wr_q    <= '0;            tx_rd_q      <= '0;
      rx_wr_q    <= '0;            rx_rd_q      <= '0;
      rx_valid_q <= 1'b0;          int_req_q    <= 1'b0;
      parity_err_q <= 1'b0;        frame_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rx_meta_q  <= 1'b1;          rx_sync_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;    rx_state_q   <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;      rx_cnt_q     <= rx_cnt_d;
      tx_shift_q <= tx_shift_d;    rx_shift_q   <= rx_shift_d;
      tx_bit_q   <= tx_bit_d;      rx_bit_q     <= rx_bit_d;
      tx_par_q   <= tx_par_d;      rx_pbad_q    <= rx_pbad_d;
      txd_q      <= txd_d;         data_out_q   <= data_out_d;
      tx_wr_q    <= tx_wr_d;       tx_rd_q      <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;       rx_rd_q      <= rx_rd_d;
      rx_valid_q <= rx_valid_d;    int_req_q    <= int_req_d;
      parity_err_q <= parity_err_d; frame_err_q <= frame_err_d;
      overrun_q  <= overrun_d;
      rx_meta_q  <= RxD;           rx_sync_q    <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  assign TxD            = txd_q;
  assign write_not_busy = !tx_full;
  assign data_out       = data_out_q;
  assign rx_valid       = rx_valid_q;
  assign int_req        = int_req_q;
  assign parity_err     = parity_err_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_uart_fifo_port.sv
// Self-checking bench for uart_fifo_port: serial frames are compared against an
// ideal bit list, received bytes against a queue model of the RX FIFO.
module tb_uart_fifo_port;
  localparam int DIV   = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = 11 * DIV;
  // Edges from driving a start bit to the RX push: two sync flops, one edge-detect flop,
  // half a bit, ten bit times; read_enable is driven one cycle earlier to coincide.
  localparam int PUSH_OFS = 3 + DIV / 2 + 10 * DIV - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic       write_enable = 1'b0, read_enable = 1'b0, int_ack = 1'b0, err_clr = 1'b0;
  logic       write_not_busy, rx_valid, int_req, parity_err, frame_err, overrun, txd, rxd;
  logic       rxd_drv = 1'b1, loopback = 1'b0;
  int         n_tests = 0, n_fail = 0;

  assign rxd = loopback ? txd : rxd_drv;
  always #5 clk = ~clk;

  uart_fifo_port #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
                   .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .write_enable(write_enable),
    .write_not_busy(write_not_busy), .read_enable(read_enable), .data_out(data_out),
    .rx_valid(rx_valid), .int_req(int_req), .int_ack(int_ack), .err_clr(err_clr),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .TxD(txd), .RxD(rxd));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Index 0 = start, 1..8 = data LSB first, 9 = even parity (optionally corrupted), 10 = stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic bad_par, input logic stop);
    return {stop, (^d) ^ bad_par, d, 1'b0};
  endfunction

  // Called on the first cycle of a start bit; each bit must hold for exactly DIV cycles.
  task automatic check_tx_frame(input logic [7:0] d, input string tag);
    logic [10:0] fb;
    fb = frame_bits(d, 1'b0, 1'b1);
    for (int b = 0; b < 11; b++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        if (txd !== fb[b]) bad++;
        tick();
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s_bit%0d: txd wrong in %0d of %0d cycles, required %b", tag, b, bad, DIV, fb[b]);
      end
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic bad_par, input logic stop, input int pop_at);
    logic [10:0] fb;
    fb = frame_bits(d, bad_par, stop);
    for (int c = 0; c < FRAME; c++) begin
      rxd_drv     = fb[c / DIV];
      read_enable = (c == pop_at);
      tick();
    end
    rxd_drv = 1'b1;
    read_enable = 1'b0;
    tick(4);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pop_rx();
    read_enable = 1'b1; tick(); read_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(3); rst = 1'b1; tick();
    n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b required 1", txd); end
    n_tests++; if (write_not_busy !== 1'b1) begin n_fail++; $display("FAIL reset_wnb: got %b required 1", write_not_busy); end
    n_tests++; if (rx_valid !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL reset_rx: valid %b data %h required 0/00", rx_valid, data_out); end
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b required 0", int_req); end
    n_tests++; if ({parity_err, frame_err, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b required 000", {parity_err, frame_err, overrun}); end
  endtask

  task automatic test_tx_frame();
    data_in = 8'hA5; write_enable = 1'b1; tick(); write_enable = 1'b0;
    n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_early_start: txd %b required 1 one edge after write", txd); end
    n_tests++; if (write_not_busy !== 1'b1) begin n_fail++; $display("FAIL tx_wnb: got %b required 1", write_not_busy); end
    tick();
    check_tx_frame(8'hA5, "tx_a5");
    n_tests++; if (txd !== 1'b1 || write_not_busy !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after: txd %b wnb %b required 1/1", txd, write_not_busy); end
  endtask

  task automatic test_loopback();
    int n;
    loopback = 1'b1;
    data_in = 8'h3C; write_enable = 1'b1; tick();
    data_in = 8'hFF; tick(); write_enable = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 2 * FRAME + 50) begin tick(); n++; end
    n_tests++; if (rx_valid !== 1'b1 || data_out !== 8'h3C) begin n_fail++; $display("FAIL lb_first: valid %b data %h required 1/3c", rx_valid, data_out); end
    n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL lb_int_set: got %b required 1", int_req); end
    pulse_ack();
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL lb_int_ack: got %b required 0", int_req); end
    n = 0;
    while (int_req !== 1'b1 && n < FRAME + 50) begin tick(); n++; end
    n_tests++; if (int_req !== 1'b1 || data_out !== 8'h3C) begin n_fail++; $display("FAIL lb_second_push: int %b head %h required 1/3c", int_req, data_out); end
    pop_rx();
    n_tests++; if (rx_valid !== 1'b1 || data_out !== 8'hFF) begin n_fail++; $display("FAIL lb_after_read: valid %b data %h required 1/ff", rx_valid, data_out); end
    pop_rx();
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL lb_empty: valid %b required 0", rx_valid); end
    pulse_ack(); tick(20); loopback = 1'b0;
  endtask

  task automatic test_loopback_random();
    logic [7:0] q[$];
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(255)));
    loopback = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin data_in = q[i]; write_enable = 1'b1; tick(); end
        write_enable = 1'b0;
      end
      begin
        tick(2);
        for (int i = 0; i < 6; i++) check_tx_frame(q[i], $sformatf("lbr%0d", i));
      end
    join
    tick(10);
    loopback = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (rx_valid !== 1'b1 || data_out !== q[i]) begin n_fail++; $display("FAIL lbr_rx%0d: valid %b data %h required 1/%h", i, rx_valid, data_out, q[i]); end
      pop_rx();
    end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL lbr_empty: valid %b required 0", rx_valid); end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] b;
    fork
      begin
        b = 8'($urandom_range(255)); q.push_back(b);
        data_in = b; write_enable = 1'b1; tick(); write_enable = 1'b0; tick();
        for (int i = 1; i <= DEPTH + 1; i++) begin
          b = 8'($urandom_range(255));
          n_tests++; if (write_not_busy !== (i <= DEPTH)) begin n_fail++; $display("FAIL b2b_wnb%0d: got %b required %b", i, write_not_busy, i <= DEPTH); end
          if (q.size() - 1 < DEPTH) q.push_back(b);
          data_in = b; write_enable = 1'b1; tick();
        end
        write_enable = 1'b0;
      end
      begin
        tick(2);
        check_tx_frame(q[0], "b2b0");
        for (int i = 1; i <= DEPTH; i++) check_tx_frame(q[i], $sformatf("b2b%0d", i));
      end
    join
    n_tests++; if (txd !== 1'b1 || write_not_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_drained: txd %b wnb %b required 1/1", txd, write_not_busy); end
    tick(DIV);
    n_tests++; if (txd !== 1'b1) begin n_fail++; $display("FAIL b2b_extra_frame: txd %b required 1 (17th write should be lost)", txd); end
  endtask

  task automatic test_rx_errors();
    send_rx_frame(8'h55, 1'b1, 1'b1, -1);
    n_tests++; if (parity_err !== 1'b1 || frame_err !== 1'b0) begin n_fail++; $display("FAIL err_parity: par %b frm %b required 1/0", parity_err, frame_err); end
    n_tests++; if (rx_valid !== 1'b0 || int_req !== 1'b1) begin n_fail++; $display("FAIL err_parity_side: valid %b int %b required 0/1", rx_valid, int_req); end
    pulse_ack();
    send_rx_frame(8'h55, 1'b0, 1'b0, -1);
    n_tests++; if (frame_err !== 1'b1 || parity_err !== 1'b1) begin n_fail++; $display("FAIL err_frame: frm %b par %b required 1/1", frame_err, parity_err); end
    n_tests++; if (rx_valid !== 1'b0 || int_req !== 1'b1) begin n_fail++; $display("FAIL err_frame_side: valid %b int %b required 0/1", rx_valid, int_req); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_tests++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: par %b frm %b required 0/0", parity_err, frame_err); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] q[$];
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(255)); q.push_back(b);
      send_rx_frame(b, 1'b0, 1'b1, -1);
    end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b required 0 with %0d entries", overrun, DEPTH); end
    send_rx_frame(8'($urandom_range(255)), 1'b0, 1'b1, -1);
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", overrun); end
    n_tests++; if (rx_valid !== 1'b1 || data_out !== q[0]) begin n_fail++; $display("FAIL ovr_head: valid %b data %h required 1/%h", rx_valid, data_out, q[0]); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    b = 8'($urandom_range(255));
    send_rx_frame(b, 1'b0, 1'b1, PUSH_OFS);
    void'(q.pop_front());
    q.push_back(b);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_push_pop: overrun %b required 0", overrun); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (rx_valid !== 1'b1 || data_out !== q[i]) begin n_fail++; $display("FAIL ovr_drain%0d: valid %b data %h required 1/%h", i, rx_valid, data_out, q[i]); end
      pop_rx();
    end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_count: valid %b required 0 after %0d reads", rx_valid, DEPTH); end
    pulse_ack();
  endtask

  task automatic test_glitch_and_reset();
    int lows;
    rxd_drv = 1'b0; tick(4); rxd_drv = 1'b1;
    tick(2 * FRAME);
    n_tests++; if (rx_valid !== 1'b0 || int_req !== 1'b0) begin n_fail++; $display("FAIL glitch_rx: valid %b int %b required 0/0", rx_valid, int_req); end
    n_tests++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_err: par %b frm %b required 0/0", parity_err, frame_err); end
    send_rx_frame(8'($urandom_range(255)), 1'b0, 1'b1, -1);
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rx: valid %b required 1", rx_valid); end
    write_enable = 1'b1;
    data_in = 8'h00; tick();
    data_in = 8'h12; tick();
    data_in = 8'h34; tick();
    write_enable = 1'b0;
    tick(30);
    n_tests++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rst_pre_tx: txd %b required 0 mid data bit", txd); end
    #3 rst = 1'b0;
    #1;
    n_tests++; if (txd !== 1'b1 || write_not_busy !== 1'b1) begin n_fail++; $display("FAIL rst_async_tx: txd %b wnb %b required 1/1", txd, write_not_busy); end
    n_tests++; if (rx_valid !== 1'b0 || data_out !== 8'h00 || int_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_rx: valid %b data %h int %b required 0/00/0", rx_valid, data_out, int_req); end
    @(posedge clk); #1 rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (txd !== 1'b1) lows++;
      tick();
    end
    n_tests++; if (lows != 0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fifos_empty: %0d low txd cycles, valid %b required 0/0", lows, rx_valid); end
    data_in = 8'h5A; write_enable = 1'b1; tick(); write_enable = 1'b0; tick();
    check_tx_frame(8'h5A, "rst_recover");
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_loopback_random();
    test_back_to_back();
    test_rx_errors();
    test_overrun();
    test_glitch_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
